// File: rtl/step_pulse_decoder.sv
// Receive side of a STEP/DIR interface: synchronises and debounces the pins, then
// tracks absolute position and per-burst step count, step period and burst result.
module step_pulse_decoder #(
  parameter int unsigned FILTER_CYCLES = 16,
  parameter int unsigned IDLE_CYCLES   = 1000000,
  parameter int unsigned EXPECT_STEPS  = 20,
  parameter int unsigned POS_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             enable,
  input  logic             pos_clear,
  output logic             step_strobe,
  output logic [POS_W-1:0] position,
  output logic [15:0]      burst_count,
  output logic [31:0]      period,
  output logic             burst_done,
  output logic             burst_mismatch
);

  localparam int unsigned FILT_W = $clog2(FILTER_CYCLES);
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  // Input path: index 0 is STEP, index 1 is DIR.
  logic [1:0]        raw;
  logic [1:0]        meta_q, sync_q;
  logic [1:0]        filt_q, filt_d;
  logic [FILT_W-1:0] fcnt_q [2];
  logic [FILT_W-1:0] fcnt_d [2];
  logic              step_prev_q;
  logic              rise_q, rise_d;

  // Burst tracking.
  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [31:0]       gap_q, gap_d;
  logic              pend_q, pend_d;
  logic              ev;
  logic              strobe_q, strobe_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [15:0]       bcnt_q, bcnt_d;
  logic [31:0]       period_q, period_d;
  logic              done_q, done_d;
  logic              mism_q, mism_d;

  assign raw = {dir_in, step_in};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_W'(FILTER_CYCLES - 1)) filt_d[i] = sync_q[i];
        else                                         fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
    rise_d = filt_q[0] & ~step_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      filt_q      <= '0;
      fcnt_q[0]   <= '0;
      fcnt_q[1]   <= '0;
      step_prev_q <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      meta_q      <= raw;
      sync_q      <= meta_q;
      filt_q      <= filt_d;
      fcnt_q[0]   <= fcnt_d[0];
      fcnt_q[1]   <= fcnt_d[1];
      step_prev_q <= filt_q[0];
      rise_q      <= rise_d;
    end
  end

  always_comb begin
    // A rise landing in the DONE cycle is replayed from pend_q once back in IDLE.
    ev       = enable & (rise_q | pend_q) & (state_q != DONE);
    state_d  = state_q;
    idle_d   = idle_q;
    pend_d   = 1'b0;
    gap_d    = (gap_q == 32'hFFFF_FFFF) ? gap_q : gap_q + 1'b1;
    strobe_d = ev;
    pos_d    = pos_q;
    bcnt_d   = bcnt_q;
    period_d = period_q;
    done_d   = 1'b0;
    mism_d   = mism_q;

    if (ev) begin
      pos_d = filt_q[1] ? pos_q + 1'b1 : pos_q - 1'b1;
      gap_d = 32'd1;
    end
    if (pos_clear) pos_d = '0;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = ACTIVE;
          bcnt_d  = 16'd1;
          idle_d  = '0;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (ev) begin
          if (bcnt_q != 16'hFFFF) bcnt_d = bcnt_q + 1'b1;
          period_d = gap_q;
          idle_d   = '0;
        end else if (idle_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          mism_d  = (bcnt_q != 16'(EXPECT_STEPS));
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        pend_d  = enable & rise_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idle_q   <= '0;
      gap_q    <= '0;
      pend_q   <= 1'b0;
      strobe_q <= 1'b0;
      pos_q    <= '0;
      bcnt_q   <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      gap_q    <= gap_d;
      pend_q   <= pend_d;
      strobe_q <= strobe_d;
      pos_q    <= pos_d;
      bcnt_q   <= bcnt_d;
      period_q <= period_d;
      done_q   <= done_d;
      mism_q   <= mism_d;
    end
  end

  assign step_strobe    = strobe_q;
  assign position       = pos_q;
  assign burst_count    = bcnt_q;
  assign period         = period_q;
  assign burst_done     = done_q;
  assign burst_mismatch = mism_q;

endmodule
